// File: rtl/mbus_arb.sv
// mbus_arb: two-requester arbiter onto a shared single-beat memory bus, read and write channels independent.
// Latency: grant is registered in IDLE, so a request reaches the mbus one cycle later; min 3 cycles per transaction.
// Backpressure: mbus ready/valid are routed only to the granted master; macro MBUS_ARB_RR_EN selects round-robin ties.

module mbus_arb #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,

   // requester 0
   input  logic [ADDR_WIDTH-1:0]   m0_ar_addr_i,
   input  logic                    m0_ar_valid_i,
   output logic                    m0_ar_ready_o,
   output logic [DATA_WIDTH-1:0]   m0_r_data_o,
   output logic                    m0_r_valid_o,
   input  logic                    m0_r_ready_i,
   input  logic [ADDR_WIDTH-1:0]   m0_aw_addr_i,
   input  logic                    m0_aw_valid_i,
   output logic                    m0_aw_ready_o,
   input  logic [DATA_WIDTH-1:0]   m0_w_data_i,
   input  logic [DATA_WIDTH/8-1:0] m0_w_strb_i,
   input  logic                    m0_w_valid_i,
   output logic                    m0_b_resp_o,
   output logic                    m0_b_valid_o,
   input  logic                    m0_b_ready_i,

   // requester 1
   input  logic [ADDR_WIDTH-1:0]   m1_ar_addr_i,
   input  logic                    m1_ar_valid_i,
   output logic                    m1_ar_ready_o,
   output logic [DATA_WIDTH-1:0]   m1_r_data_o,
   output logic                    m1_r_valid_o,
   input  logic                    m1_r_ready_i,
   input  logic [ADDR_WIDTH-1:0]   m1_aw_addr_i,
   input  logic                    m1_aw_valid_i,
   output logic                    m1_aw_ready_o,
   input  logic [DATA_WIDTH-1:0]   m1_w_data_i,
   input  logic [DATA_WIDTH/8-1:0] m1_w_strb_i,
   input  logic                    m1_w_valid_i,
   output logic                    m1_b_resp_o,
   output logic                    m1_b_valid_o,
   input  logic                    m1_b_ready_i,

   // shared bus, read side
   output logic [ADDR_WIDTH-1:0]   mbus_ar_addr_o,
   output logic                    mbus_ar_valid_o,
   input  logic                    mbus_ar_ready_i,
   input  logic [DATA_WIDTH-1:0]   mbus_r_data_i,
   input  logic                    mbus_r_valid_i,
   output logic                    mbus_r_ready_o,

   // shared bus, write side
   output logic [ADDR_WIDTH-1:0]   mbus_aw_addr_o,
   output logic                    mbus_aw_valid_o,
   input  logic                    mbus_aw_ready_i,
   output logic [DATA_WIDTH-1:0]   mbus_w_data_o,
   output logic [DATA_WIDTH/8-1:0] mbus_w_strb_o,
   output logic                    mbus_w_valid_o,
   input  logic                    mbus_b_resp_i,
   input  logic                    mbus_b_valid_i,
   output logic                    mbus_b_ready_o,

   // status
   output logic                    rd_busy_o,
   output logic                    wr_busy_o
);

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_ADDR = 2'd1,
      WR_RESP = 2'd2
   } wr_state_e;

   rd_state_e rd_state_q;
   wr_state_e wr_state_q;

   // grant: 0 selects m0, 1 selects m1; only rewritten in IDLE
   logic rd_gnt_q, rd_gnt_d;
   logic wr_gnt_q, wr_gnt_d;
   logic rd_busy_q, wr_busy_q;

   logic rd_in_addr, rd_in_data;
   logic wr_in_addr, wr_in_resp;
   logic rd_req_any, wr_req_any;

`ifdef MBUS_ARB_RR_EN
   // last-granted master per channel; resets to m1 so m0 wins the first tie
   logic rd_last_q, wr_last_q;

   // round-robin: on a tie, pick whichever master was not granted last
   function automatic logic arb_pick(input logic v0, input logic v1, input logic last);
      if (v0 && v1) begin
         return ~last;
      end
      return v1;
   endfunction

   // next grant for each channel, evaluated while the channel is idle
   always_comb begin
      rd_gnt_d = arb_pick(m0_ar_valid_i, m1_ar_valid_i, rd_last_q);
      wr_gnt_d = arb_pick(m0_aw_valid_i, m1_aw_valid_i, wr_last_q);
   end
`else
   // fixed priority: m1 only when m0 is not asking
   function automatic logic arb_pick(input logic v0, input logic v1);
      return v1 & ~v0;
   endfunction

   // next grant for each channel, evaluated while the channel is idle
   always_comb begin
      rd_gnt_d = arb_pick(m0_ar_valid_i, m1_ar_valid_i);
      wr_gnt_d = arb_pick(m0_aw_valid_i, m1_aw_valid_i);
   end
`endif

   assign rd_req_any = m0_ar_valid_i | m1_ar_valid_i;
   assign wr_req_any = m0_aw_valid_i | m1_aw_valid_i;

   assign rd_in_addr = (rd_state_q == RD_ADDR);
   assign rd_in_data = (rd_state_q == RD_DATA);
   assign wr_in_addr = (wr_state_q == WR_ADDR);
   assign wr_in_resp = (wr_state_q == WR_RESP);

   // read channel FSM: one address and exactly one data beat per grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state_q <= RD_IDLE;
         rd_gnt_q   <= 1'b0;
         rd_busy_q  <= 1'b0;
`ifdef MBUS_ARB_RR_EN
         rd_last_q  <= 1'b1;
`endif
      end else begin
         case (rd_state_q)
            RD_IDLE: begin
               if (rd_req_any) begin
                  rd_gnt_q   <= rd_gnt_d;
                  rd_state_q <= RD_ADDR;
                  rd_busy_q  <= 1'b1;
`ifdef MBUS_ARB_RR_EN
                  rd_last_q  <= rd_gnt_d;
`endif
               end
            end
            RD_ADDR: begin
               if (mbus_ar_valid_o && mbus_ar_ready_i) begin
                  rd_state_q <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (mbus_r_valid_i && mbus_r_ready_o) begin
                  rd_state_q <= RD_IDLE;
                  rd_busy_q  <= 1'b0;
               end
            end
            default: begin
               rd_state_q <= RD_IDLE;
               rd_busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // write channel FSM: address and the single data beat go together, then wait for the response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q <= WR_IDLE;
         wr_gnt_q   <= 1'b0;
         wr_busy_q  <= 1'b0;
`ifdef MBUS_ARB_RR_EN
         wr_last_q  <= 1'b1;
`endif
      end else begin
         case (wr_state_q)
            WR_IDLE: begin
               if (wr_req_any) begin
                  wr_gnt_q   <= wr_gnt_d;
                  wr_state_q <= WR_ADDR;
                  wr_busy_q  <= 1'b1;
`ifdef MBUS_ARB_RR_EN
                  wr_last_q  <= wr_gnt_d;
`endif
               end
            end
            WR_ADDR: begin
               if (mbus_aw_valid_o && mbus_aw_ready_i) begin
                  wr_state_q <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (mbus_b_valid_i && mbus_b_ready_o) begin
                  wr_state_q <= WR_IDLE;
                  wr_busy_q  <= 1'b0;
               end
            end
            default: begin
               wr_state_q <= WR_IDLE;
               wr_busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // read routing: granted master drives the bus in ADDR and sees the beat in DATA
   always_comb begin
      mbus_ar_addr_o  = rd_gnt_q ? m1_ar_addr_i : m0_ar_addr_i;
      mbus_ar_valid_o = rd_in_addr & (rd_gnt_q ? m1_ar_valid_i : m0_ar_valid_i);
      mbus_r_ready_o  = rd_in_data & (rd_gnt_q ? m1_r_ready_i : m0_r_ready_i);

      m0_ar_ready_o   = rd_in_addr & ~rd_gnt_q & mbus_ar_ready_i;
      m1_ar_ready_o   = rd_in_addr &  rd_gnt_q & mbus_ar_ready_i;
      m0_r_valid_o    = rd_in_data & ~rd_gnt_q & mbus_r_valid_i;
      m1_r_valid_o    = rd_in_data &  rd_gnt_q & mbus_r_valid_i;
      // data is broadcast; only the qualified valid matters
      m0_r_data_o     = mbus_r_data_i;
      m1_r_data_o     = mbus_r_data_i;
   end

   // write routing: address and beat from the granted master, response back to it only
   always_comb begin
      mbus_aw_addr_o  = wr_gnt_q ? m1_aw_addr_i : m0_aw_addr_i;
      mbus_aw_valid_o = wr_in_addr & (wr_gnt_q ? m1_aw_valid_i : m0_aw_valid_i);
      mbus_w_data_o   = wr_gnt_q ? m1_w_data_i : m0_w_data_i;
      mbus_w_strb_o   = wr_gnt_q ? m1_w_strb_i : m0_w_strb_i;
      mbus_w_valid_o  = wr_in_addr
                        & (wr_gnt_q ? (m1_aw_valid_i & m1_w_valid_i)
                                    : (m0_aw_valid_i & m0_w_valid_i));
      mbus_b_ready_o  = wr_in_resp & (wr_gnt_q ? m1_b_ready_i : m0_b_ready_i);

      m0_aw_ready_o   = wr_in_addr & ~wr_gnt_q & mbus_aw_ready_i;
      m1_aw_ready_o   = wr_in_addr &  wr_gnt_q & mbus_aw_ready_i;
      m0_b_valid_o    = wr_in_resp & ~wr_gnt_q & mbus_b_valid_i;
      m1_b_valid_o    = wr_in_resp &  wr_gnt_q & mbus_b_valid_i;
      m0_b_resp_o     = mbus_b_resp_i & ~wr_gnt_q;
      m1_b_resp_o     = mbus_b_resp_i &  wr_gnt_q;
   end

   assign rd_busy_o = rd_busy_q;
   assign wr_busy_o = wr_busy_q;

endmodule
